// File: rtl/audio_out_mc.sv
`timescale 1ns/1ps
// audio_out_mc: per-channel tear rejection, sign conversion, DC blocker and soft mute gain ramp.
// Latency: out_valid NUM_CH+1 cycles after an accepted sample_ce (NUM_CH+2 with volume stage).
// Backpressure: none; a sample_ce arriving while busy is dropped and flagged in sticky overrun.
//
// Ports: clk/reset (async, active-high); sample_ce output-rate strobe; is_signed selects
// two's complement vs offset-binary core samples; core_in packed raw samples (channel k at
// [k*SAMPLE_W +: SAMPLE_W]); mute_req ramps gain down; audio_out processed signed samples;
// out_valid one-cycle update pulse; busy FSM not idle; gain_full gain==256; overrun sticky.
// Optional: define AUDIO_OUT_MC_VOLUME_EN to add the per-channel volume port and stage.
module audio_out_mc #(
   parameter int NUM_CH          = 2,
   parameter int SAMPLE_W        = 16,
   parameter int DC_SHIFT        = 8,
   parameter int STARTUP_SAMPLES = 1024
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       sample_ce,
   input  logic                       is_signed,
   input  logic [NUM_CH*SAMPLE_W-1:0] core_in,
   input  logic                       mute_req,
`ifdef AUDIO_OUT_MC_VOLUME_EN
   input  logic [NUM_CH*8-1:0]        volume,
`endif
   output logic [NUM_CH*SAMPLE_W-1:0] audio_out,
   output logic                       out_valid,
   output logic                       busy,
   output logic                       gain_full,
   output logic                       overrun
);

   localparam int W   = SAMPLE_W;
   localparam int DW  = SAMPLE_W + 2;
   localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int SCW = (STARTUP_SAMPLES < 1) ? 1 : $clog2(STARTUP_SAMPLES + 1);
   localparam logic [CW-1:0]  CH_LAST   = CW'(NUM_CH - 1);
   localparam logic [SCW-1:0] START_MAX = SCW'(STARTUP_SAMPLES);
   localparam logic [8:0]     GAIN_MAX  = 9'd256;

   typedef enum logic [1:0] {IDLE, PROC, COMMIT} state_t;

   state_t state, state_n;

   logic [NUM_CH-1:0][W-1:0] s1, s2, stable;
   logic [NUM_CH-1:0][W-1:0] x_conv, x_snap, x_prev, y_prev, staged;
   logic [CW-1:0]            ch;
   logic [8:0]               gain;
   logic [SCW-1:0]           startup_cnt;
   logic                     armed;
   logic                     ce_ok;

   // Stabiliser: only a value seen identically on two consecutive clocks is trusted, so a
   // multi-bit core word caught mid-update never reaches the datapath.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1     <= '0;
         s2     <= '0;
         stable <= '0;
      end else begin
         s1 <= core_in;
         s2 <= s1;
         for (int k = 0; k < NUM_CH; k++) begin
            if (s1[k] == s2[k]) stable[k] <= s2[k];
         end
      end
   end

   // Offset binary becomes two's complement by flipping the MSB.
   always_comb begin
      x_conv = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         x_conv[k] = {~is_signed ^ stable[k][W-1], stable[k][W-2:0]};
      end
   end

   // armed is low on the first edge after reset release, so a strobe overlapping the
   // deassertion is not taken.
   assign ce_ok     = sample_ce && armed;
   assign busy      = (state != IDLE);
   assign gain_full = (gain == GAIN_MAX);

   // Shared channel datapath: DC blocker then gain, for the channel selected by ch.
   logic [W-1:0]          x_cur, xp_cur, yp_cur;
   logic signed [W-1:0]   yp_sh;
   logic signed [DW-1:0]  dc_d;
   logic signed [W-1:0]   y_sat;
   logic signed [W+7:0]   g_prod;
   logic [W-1:0]          g_res;

   always_comb begin
      x_cur  = x_snap[ch];
      xp_cur = x_prev[ch];
      yp_cur = y_prev[ch];
      yp_sh  = $signed(yp_cur) >>> DC_SHIFT;
      dc_d   = $signed({{2{x_cur[W-1]}}, x_cur})
             - $signed({{2{xp_cur[W-1]}}, xp_cur})
             + $signed({{2{yp_cur[W-1]}}, yp_cur})
             - $signed({{2{yp_sh[W-1]}}, yp_sh});
      // Top three bits all equal means d fits in W bits; otherwise clamp by sign.
      if ((&dc_d[DW-1:W-1]) || (~|dc_d[DW-1:W-1])) begin
         y_sat = dc_d[W-1:0];
      end else if (dc_d[DW-1]) begin
         y_sat = {1'b1, {(W-1){1'b0}}};
      end else begin
         y_sat = {1'b0, {(W-1){1'b1}}};
      end
      // |y*gain| <= 2^(W+7), so W+8 bits hold the product exactly.
      g_prod = y_sat * $signed({1'b0, gain});
      g_res  = W'(g_prod >>> 8);
   end

`ifdef AUDIO_OUT_MC_VOLUME_EN
   // Volume stage on the committed samples: g*(vol+1)>>>8, vol=255 is unity.
   logic [NUM_CH-1:0][W-1:0] vol_out;
   logic signed [W+7:0]      v_prod;
   always_comb begin
      vol_out = '0;
      v_prod  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         v_prod     = $signed(staged[k]) * $signed({1'b0, {1'b0, volume[k*8 +: 8]} + 9'd1});
         vol_out[k] = W'(v_prod >>> 8);
      end
   end
`else
   // Staged set including the channel finishing this cycle, so audio_out can load on the
   // edge that enters COMMIT and out_valid lines up with the new data.
   logic [NUM_CH-1:0][W-1:0] staged_n;
   always_comb begin
      staged_n     = staged;
      staged_n[ch] = g_res;
   end
`endif

   // FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (ce_ok) state_n = PROC;
         PROC:    if (ch == CH_LAST) state_n = COMMIT;
         COMMIT:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed       <= 1'b0;
         x_snap      <= '0;
         x_prev      <= '0;
         y_prev      <= '0;
         staged      <= '0;
         ch          <= '0;
         gain        <= '0;
         startup_cnt <= '0;
         audio_out   <= '0;
         out_valid   <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         armed     <= 1'b1;
         out_valid <= 1'b0;
         if (sample_ce && (state != IDLE)) overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (ce_ok) begin
                  x_snap <= x_conv;
                  ch     <= '0;
               end
            end
            PROC: begin
               x_prev[ch] <= x_cur;
               y_prev[ch] <= y_sat;
               staged[ch] <= g_res;
               ch         <= ch + CW'(1);
`ifndef AUDIO_OUT_MC_VOLUME_EN
               if (ch == CH_LAST) begin
                  audio_out <= staged_n;
                  out_valid <= 1'b1;
               end
`endif
            end
            COMMIT: begin
`ifdef AUDIO_OUT_MC_VOLUME_EN
               audio_out <= vol_out;
               out_valid <= 1'b1;
`endif
               // Startup completion is judged on the count before this commit.
               if (mute_req) begin
                  if (gain != 9'd0) gain <= gain - 9'd1;
               end else if (startup_cnt == START_MAX) begin
                  if (gain != GAIN_MAX) gain <= gain + 9'd1;
               end
               if (startup_cnt != START_MAX) startup_cnt <= startup_cnt + SCW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_audio_out_mc.sv
`timescale 1ns/1ps
module tb_audio_out_mc;
   localparam int NUM_CH = 2;
   localparam int SW     = 16;
`ifdef AUDIO_OUT_MC_VOLUME_EN
   localparam int LAT = NUM_CH + 2;
`else
   localparam int LAT = NUM_CH + 1;
`endif

   logic                    clk       = 1'b0;
   logic                    reset     = 1'b0;
   logic                    sample_ce = 1'b0;
   logic                    is_signed = 1'b1;
   logic                    mute_req  = 1'b0;
   logic [NUM_CH*SW-1:0]    core_in   = '0;
`ifdef AUDIO_OUT_MC_VOLUME_EN
   logic [NUM_CH*8-1:0]     volume    = '1;
`endif
   logic [NUM_CH*SW-1:0]    audio_out;
   logic                    out_valid, busy, gain_full, overrun;

   audio_out_mc #(
      .NUM_CH(NUM_CH), .SAMPLE_W(SW), .DC_SHIFT(8), .STARTUP_SAMPLES(4)
   ) dut (
      .clk(clk), .reset(reset), .sample_ce(sample_ce), .is_signed(is_signed),
      .core_in(core_in), .mute_req(mute_req),
`ifdef AUDIO_OUT_MC_VOLUME_EN
      .volume(volume),
`endif
      .audio_out(audio_out), .out_valid(out_valid), .busy(busy),
      .gain_full(gain_full), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;
   int ovld_cnt = 0;

   // Scoreboard
   logic [NUM_CH*SW-1:0] exp_dat_q [$];
   int                   exp_cyc_q [$];
   logic [NUM_CH*SW-1:0] mon_dat;
   int                   mon_cyc;

   // Reference model state
   int m_xp [NUM_CH];
   int m_yp [NUM_CH];
   int m_gain;
   int m_start;

   function automatic int fdiv(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
      return q;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < NUM_CH; k++) begin
         m_xp[k] = 0;
         m_yp[k] = 0;
      end
      m_gain  = 0;
      m_start = 0;
      exp_dat_q.delete();
      exp_cyc_q.delete();
   endtask

   task automatic model_push(input logic [NUM_CH*SW-1:0] raw);
      logic [NUM_CH*SW-1:0] e;
      logic [SW-1:0]        r;
      int x, d, y, o;
      e = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         r = raw[k*SW +: SW];
         x = is_signed ? int'($signed(r)) : int'(r) - 32768;
         d = x - m_xp[k] + m_yp[k] - fdiv(m_yp[k], 256);
         y = (d > 32767) ? 32767 : ((d < -32768) ? -32768 : d);
         o = fdiv(y * m_gain, 256);
`ifdef AUDIO_OUT_MC_VOLUME_EN
         o = fdiv(o * (int'(volume[k*8 +: 8]) + 1), 256);
`endif
         e[k*SW +: SW] = SW'(o);
         m_xp[k] = x;
         m_yp[k] = y;
      end
      if (mute_req) begin
         if (m_gain > 0) m_gain = m_gain - 1;
      end else if (m_start >= 4) begin
         if (m_gain < 256) m_gain = m_gain + 1;
      end
      if (m_start < 4) m_start = m_start + 1;
      exp_dat_q.push_back(e);
      exp_cyc_q.push_back(cyc + LAT);
   endtask

   // Output monitor: compare every out_valid against the scoreboard head.
   always @(negedge clk) begin
      if (out_valid) begin
         ovld_cnt = ovld_cnt + 1;
         checks = checks + 1;
         if (exp_dat_q.size() == 0) begin
            failures = failures + 1;
            $display("FAIL unexpected_out_valid cyc=%0d audio_out=%h required no pulse", cyc, audio_out);
         end else begin
            mon_dat = exp_dat_q.pop_front();
            mon_cyc = exp_cyc_q.pop_front();
            if (audio_out !== mon_dat) begin
               failures = failures + 1;
               $display("FAIL audio_out cyc=%0d got=%h exp=%h", cyc, audio_out, mon_dat);
            end
            checks = checks + 1;
            if (cyc !== mon_cyc) begin
               failures = failures + 1;
               $display("FAIL latency out_valid_cyc=%0d exp_cyc=%0d", cyc, mon_cyc);
            end
         end
      end else if (exp_cyc_q.size() != 0 && cyc > exp_cyc_q[0]) begin
         checks = checks + 1;
         failures = failures + 1;
         $display("FAIL missing_out_valid cyc=%0d exp_cyc=%0d", cyc, exp_cyc_q[0]);
         mon_dat = exp_dat_q.pop_front();
         mon_cyc = exp_cyc_q.pop_front();
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      sample_ce = 1'b0;
      reset     = 1'b1;
      tick(3);
      reset = 1'b0;
      model_clear();
      tick(2);
   endtask

   // One 64-cycle output period with a scoreboarded strobe in it.
   task automatic strobe();
      tick(8);
      model_push(core_in);
      sample_ce = 1'b1;
      tick(1);
      sample_ce = 1'b0;
      tick(55);
   endtask

   task automatic test_reset();
      int base;
      is_signed = 1'b1;
      core_in   = 32'h1000_1000;
      tick(1);
      reset = 1'b1;
      tick(3);
      checks = checks + 1;
      if (audio_out !== '0) begin failures++; $display("FAIL reset_audio_out got=%h exp=0", audio_out); end
      checks = checks + 1;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL reset_valid_busy got=%b%b exp=00", out_valid, busy);
      end
      checks = checks + 1;
      if (overrun !== 1'b0 || gain_full !== 1'b0) begin
         failures++; $display("FAIL reset_overrun_gainfull got=%b%b exp=00", overrun, gain_full);
      end
      // Strobe coinciding with reset release must be ignored.
      model_clear();
      base      = ovld_cnt;
      sample_ce = 1'b1;
      reset     = 1'b0;
      tick(1);
      sample_ce = 1'b0;
      checks = checks + 1;
      if (busy !== 1'b0) begin failures++; $display("FAIL ce_at_release_busy got=%b exp=0", busy); end
      tick(8);
      checks = checks + 1;
      if (ovld_cnt !== base) begin failures++; $display("FAIL ce_at_release_pulses got=%0d exp=%0d", ovld_cnt - base, 0); end
   endtask

   task automatic test_startup_ramp();
      int base;
      base = ovld_cnt;
      for (int i = 1; i <= 260; i++) begin
         strobe();
         if (i <= 5) begin
            checks = checks + 1;
            if (audio_out !== '0) begin failures++; $display("FAIL startup_zero strobe=%0d got=%h exp=0", i, audio_out); end
         end
         if (i == 259) begin
            checks = checks + 1;
            if (gain_full !== 1'b0) begin failures++; $display("FAIL gain_full_early got=%b exp=0", gain_full); end
         end
      end
      checks = checks + 1;
      if (gain_full !== 1'b1) begin failures++; $display("FAIL gain_full_260 got=%b exp=1", gain_full); end
      checks = checks + 1;
      if (ovld_cnt - base !== 260) begin failures++; $display("FAIL ramp_pulses got=%0d exp=260", ovld_cnt - base); end
   endtask

   task automatic test_unsigned_zero();
      do_reset();
      is_signed = 1'b0;
      core_in   = 32'h8000_8000;
      for (int i = 1; i <= 260; i++) begin
         strobe();
         checks = checks + 1;
         if (audio_out !== '0) begin failures++; $display("FAIL unsigned_zero strobe=%0d got=%h exp=0", i, audio_out); end
      end
      checks = checks + 1;
      if (gain_full !== 1'b1) begin failures++; $display("FAIL unsigned_gain_full got=%b exp=1", gain_full); end
   endtask

   task automatic test_step();
      logic [15:0] exp_c [3];
      exp_c[0] = 16'h4000;
      exp_c[1] = 16'h3FC0;
      exp_c[2] = 16'h3F81;
      is_signed = 1'b1;
      core_in   = '0;
      strobe();
      checks = checks + 1;
      if (audio_out !== '0) begin failures++; $display("FAIL step_base got=%h exp=0", audio_out); end
      core_in = 32'h0000_4000;
      for (int i = 0; i < 3; i++) begin
         strobe();
         checks = checks + 1;
         if (audio_out[15:0] !== exp_c[i] || audio_out[31:16] !== 16'h0000) begin
            failures++; $display("FAIL step_%0d got=%h exp=0000%h", i, audio_out, exp_c[i]);
         end
      end
   endtask

   task automatic test_clip();
      logic [15:0] ev;
      for (int i = 0; i < 6; i++) begin
         core_in = (i % 2 == 0) ? 32'h0000_7FFF : 32'h0000_8000;
         strobe();
         if (i >= 1) begin
            ev = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
            checks = checks + 1;
            if (audio_out[15:0] !== ev) begin failures++; $display("FAIL clip_%0d got=%h exp=%h", i, audio_out[15:0], ev); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int base;
      checks = checks + 1;
      if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_pre got=%b exp=0", overrun); end
      tick(8);
      model_push(core_in);
      sample_ce = 1'b1;
      tick(1);
      checks = checks + 1;
      if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", busy); end
      tick(1);
      sample_ce = 1'b0;
      base = ovld_cnt;
      checks = checks + 1;
      if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b exp=1", overrun); end
      tick(20);
      checks = checks + 1;
      if (ovld_cnt - base !== 1) begin failures++; $display("FAIL b2b_pulses got=%0d exp=1", ovld_cnt - base); end
      tick(34);
      strobe();
      checks = checks + 1;
      if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
   endtask

   task automatic test_stabiliser();
      logic [31:0] p;
      int base;
      p       = 32'h0000_1234;
      core_in = p;
      tick(10);
      base = ovld_cnt;
      for (int i = 0; i < 20; i++) begin
         core_in = (i % 2 == 1) ? 32'h5A5A_7000 : 32'h0F0F_0100;
         if (i == 10) begin
            model_push(p);
            sample_ce = 1'b1;
         end else begin
            sample_ce = 1'b0;
         end
         tick(1);
      end
      sample_ce = 1'b0;
      core_in   = p;
      tick(50);
      checks = checks + 1;
      if (ovld_cnt - base !== 1) begin failures++; $display("FAIL stab_pulses got=%0d exp=1", ovld_cnt - base); end
   endtask

   task automatic test_mute();
      mute_req = 1'b1;
      for (int i = 0; i <= 256; i++) begin
         core_in = (i % 2 == 0) ? 32'h0000_2000 : 32'h0000_E000;
         strobe();
         if (i == 0) begin
            checks = checks + 1;
            if (gain_full !== 1'b0) begin failures++; $display("FAIL mute_gain_full got=%b exp=0", gain_full); end
         end
      end
      checks = checks + 1;
      if (audio_out !== '0) begin failures++; $display("FAIL mute_silent got=%h exp=0", audio_out); end
      mute_req = 1'b0;
   endtask

   task automatic test_abort();
      int base;
      for (int i = 0; i < 20; i++) begin
         core_in = (i % 2 == 0) ? 32'h0000_2000 : 32'h0000_E000;
         strobe();
      end
      checks = checks + 1;
      if (audio_out[15:0] === 16'h0000) begin failures++; $display("FAIL pre_abort_nonzero got=%h exp=nonzero", audio_out); end
      tick(8);
      base      = ovld_cnt;
      sample_ce = 1'b1;
      tick(1);
      sample_ce = 1'b0;
      tick(1);
      reset = 1'b1;
      #1;
      checks = checks + 1;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL abort_busy_valid got=%b%b exp=00", busy, out_valid);
      end
      checks = checks + 1;
      if (audio_out !== '0 || overrun !== 1'b0) begin
         failures++; $display("FAIL abort_clear got=%h/%b exp=0/0", audio_out, overrun);
      end
      tick(3);
      reset = 1'b0;
      model_clear();
      tick(10);
      checks = checks + 1;
      if (ovld_cnt !== base) begin failures++; $display("FAIL abort_pulses got=%0d exp=0", ovld_cnt - base); end
      strobe();
      checks = checks + 1;
      if (ovld_cnt - base !== 1) begin failures++; $display("FAIL abort_recover got=%0d exp=1", ovld_cnt - base); end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_startup_ramp();
      test_unsigned_zero();
      test_step();
      test_clip();
      test_back_to_back();
      test_stabiliser();
      test_mute();
      test_abort();
      tick(10);
      checks = checks + 1;
      if (exp_dat_q.size() != 0) begin
         failures++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_dat_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
